// File: rtl/mem_port_arbiter_if.sv
// Request/grant/completion bus for the two-port memory arbiter plus its memory command port.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_done;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    output dma_gnt, dma_done, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    input  dma_gnt, dma_done, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// CPU/DMA single-port memory arbiter: IDLE -> ISSUE -> WAIT(MEM_LAT) -> DONE, CPU priority.
// Define MEM_ARB_STARVE_GUARD_EN to let DMA win after STARVE_MAX CPU grants while it waits.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  state_t            state;
  owner_t            owner;
  logic [3:0]        wait_cnt;
  logic              lat_we;

  logic              any_req;
  logic              dma_wins;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [7:0] starve_cnt;
  logic       starved;
  assign starved = (starve_cnt == 8'(STARVE_MAX));
`else
  logic starve_max_unused;
  assign starve_max_unused = ^32'(STARVE_MAX);
`endif

  always_comb begin
    any_req = bus.cpu_req | bus.dma_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
    dma_wins = bus.dma_req & (~bus.cpu_req | starved);
`else
    dma_wins = bus.dma_req & ~bus.cpu_req;
`endif
    win_we    = dma_wins ? bus.dma_we    : bus.cpu_we;
    win_addr  = dma_wins ? bus.dma_addr  : bus.cpu_addr;
    win_wdata = dma_wins ? bus.dma_wdata : bus.cpu_wdata;
  end

  assign busy = (state != IDLE);

  // mem_addr/mem_wdata double as the latched request fields, so they naturally hold after ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= OWN_CPU;
      wait_cnt      <= '0;
      lat_we        <= 1'b0;
      bus.cpu_gnt   <= 1'b0;
      bus.cpu_done  <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_gnt   <= 1'b0;
      bus.dma_done  <= 1'b0;
      bus.dma_rdata <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state         <= ISSUE;
            owner         <= dma_wins ? OWN_DMA : OWN_CPU;
            lat_we        <= win_we;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= win_we;
            bus.mem_addr  <= win_addr;
            bus.mem_wdata <= win_wdata;
            bus.cpu_gnt   <= ~dma_wins;
            bus.dma_gnt   <= dma_wins;
          end
`ifdef MEM_ARB_STARVE_GUARD_EN
          // dma_req high without a DMA win implies a CPU grant this edge.
          if (!bus.dma_req || dma_wins) starve_cnt <= '0;
          else                          starve_cnt <= starve_cnt + 8'd1;
`endif
        end
        ISSUE: begin
          bus.mem_en  <= 1'b0;
          bus.mem_we  <= 1'b0;
          bus.cpu_gnt <= 1'b0;
          bus.dma_gnt <= 1'b0;
          wait_cnt    <= 4'(MEM_LAT);
          state       <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd1) begin
            wait_cnt <= '0;
            state    <= DONE;
            if (!lat_we) begin
              if (owner == OWN_DMA) bus.dma_rdata <= bus.mem_rdata;
              else                  bus.cpu_rdata <= bus.mem_rdata;
            end
            bus.cpu_done <= (owner == OWN_CPU);
            bus.dma_done <= (owner == OWN_DMA);
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          bus.cpu_done <= 1'b0;
          bus.dma_done <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (default build: strict CPU priority, MEM_LAT=2).
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  exp_t        cpu_q[$];
  exp_t        dma_q[$];
  bit          gnt_log[$];
  logic [31:0] cpu_rd_last = '0;
  logic [31:0] dma_rd_last = '0;
  logic [31:0] last_addr = '0;
  int          gnt_cyc[2];
  int          done_cyc[2];

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory model: returns read data right after the command; writes return junk.
  initial begin
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_en) bus.mem_rdata = bus.mem_we ? 32'hBAD0_BAD0 : mem_f(bus.mem_addr);
    end
  end

  task automatic push_exp(input bit dma, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    if (dma) begin
      if (!we) dma_rd_last = mem_f(addr);
      e.rdata = dma_rd_last;
      dma_q.push_back(e);
    end else begin
      if (!we) cpu_rd_last = mem_f(addr);
      e.rdata = cpu_rd_last;
      cpu_q.push_back(e);
    end
  endtask

  // Monitor: per-cycle protocol rules plus scoreboard matching on gnt/done.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      check("gnt_excl", 64'(bus.cpu_gnt & bus.dma_gnt), 0);
      check("done_excl", 64'(bus.cpu_done & bus.dma_done), 0);
      check("mem_en_is_gnt", 64'(bus.mem_en), 64'(bus.cpu_gnt | bus.dma_gnt));
      if (!bus.mem_en) begin
        check("mem_we_idle", 64'(bus.mem_we), 0);
        check("mem_addr_hold", 64'(bus.mem_addr), 64'(last_addr));
      end
      for (int p = 0; p < 2; p++) begin
        logic g, d;
        g = p ? bus.dma_gnt : bus.cpu_gnt;
        d = p ? bus.dma_done : bus.cpu_done;
        if (g) begin
          if ((p ? dma_q.size() : cpu_q.size()) == 0) check("unexpected_gnt", 1, 0);
          else begin
            e = p ? dma_q[0] : cpu_q[0];
            check("issue_we", 64'(bus.mem_we), 64'(e.we));
            check("issue_addr", 64'(bus.mem_addr), 64'(e.addr));
            check("issue_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
            last_addr = e.addr;
          end
          check("busy_gnt", 64'(busy), 1);
          gnt_cyc[p] = cyc;
          gnt_log.push_back(p[0]);
        end
        if (d) begin
          if ((p ? dma_q.size() : cpu_q.size()) == 0) check("unexpected_done", 1, 0);
          else begin
            e = p ? dma_q.pop_front() : cpu_q.pop_front();
            check(p ? "dma_rdata" : "cpu_rdata",
                  64'(p ? bus.dma_rdata : bus.cpu_rdata), 64'(e.rdata));
          end
          check("gnt_to_done", 64'(cyc - gnt_cyc[p]), 64'(MEM_LAT + 1));
          check("busy_done", 64'(busy), 1);
          done_cyc[p] = cyc;
        end
      end
    end
  end

  task automatic set_port(input bit dma, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (dma) begin
      bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
  endtask

  // Called on a negedge; holds req until done and scrambles fields after the grant.
  task automatic access(input bit dma, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit chk_lat);
    int k, n;
    push_exp(dma, we, addr, wdata);
    set_port(dma, 1'b1, we, addr, wdata);
    k = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!(dma ? bus.dma_gnt : bus.cpu_gnt) && n < 40);
    if (!(dma ? bus.dma_gnt : bus.cpu_gnt)) check("gnt_timeout", 0, 1);
    else if (chk_lat) check("req_to_gnt", 64'(cyc - k), 1);
    set_port(dma, 1'b1, ~we, ~addr, ~wdata);
    n = 0;
    do begin @(negedge clk); n++; end while (!(dma ? bus.dma_done : bus.cpu_done) && n < 40);
    if (!(dma ? bus.dma_done : bus.cpu_done)) check("done_timeout", 0, 1);
    else if (chk_lat) check("req_to_done", 64'(cyc - k), 64'(MEM_LAT + 2));
    set_port(dma, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("busy_after", 64'(busy), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_busy_gnt_done", {60'd0, busy, bus.cpu_gnt | bus.dma_gnt,
          bus.cpu_done | bus.dma_done, bus.mem_en}, 0);
    check("rst_mem_we", 64'(bus.mem_we), 0);
    check("rst_mem_addr", 64'(bus.mem_addr), 0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 0);
    check("rst_rdata", {bus.cpu_rdata, bus.dma_rdata}, 0);
    cpu_q.delete();
    dma_q.delete();
    cpu_rd_last = '0;
    dma_rd_last = '0;
    last_addr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] log_bits();
    logic [7:0] b = '0;
    for (int i = 0; i < gnt_log.size() && i < 8; i++) b[i] = gnt_log[i];
    return b;
  endfunction

  initial begin
    int nd, ng, prev, n;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    do_reset();

    // Single CPU read, exact latency.
    access(1'b0, 1'b0, 32'h100, 32'h0, 1'b1);
    check("rdata_deadbeef", 64'(bus.cpu_rdata), 64'h0000_0000_DEAD_BEEF);
    // CPU write: same timing, rdata held.
    access(1'b0, 1'b1, 32'h44, 32'h1234_5678, 1'b1);
    // DMA read then DMA write 0x55 to 0x20.
    access(1'b1, 1'b0, 32'h300, 32'h0, 1'b1);
    access(1'b1, 1'b1, 32'h20, 32'h55, 1'b1);

    // Simultaneous requests: CPU first, DMA granted two cycles after cpu_done.
    gnt_log.delete();
    fork
      access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
      access(1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
    join
    check("order_len_sim", 64'(gnt_log.size()), 2);
    check("order_sim", 64'(log_bits()), 64'b10);
    check("dma_after_cpu_done", 64'(gnt_cyc[1] - done_cyc[0]), 2);

    // Both held: strict CPU priority, back-to-back spacing MEM_LAT+3.
    gnt_log.delete();
    for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b0, 32'h30, 32'h0);
    push_exp(1'b1, 1'b0, 32'h40, 32'h0);
    set_port(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    nd = 0; ng = 0; prev = 0; n = 0;
    while (nd < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.cpu_gnt) begin
        if (ng > 0) check("gnt_spacing", 64'(cyc - prev), 64'(MEM_LAT + 3));
        prev = cyc;
        ng++;
      end
      if (bus.cpu_done) nd++;
    end
    check("held_cpu_dones", 64'(nd), 3);
    bus.cpu_req = 1'b0;
    n = 0;
    while (!bus.dma_done && n < 40) begin @(negedge clk); n++; end
    check("held_dma_done", 64'(bus.dma_done), 1);
    bus.dma_req = 1'b0;
    @(negedge clk);
    check("order_len_held", 64'(gnt_log.size()), 4);
    check("order_held", 64'(log_bits()), 64'b1000);

    // Reset during WAIT: aborted silently, then normal operation resumes.
    push_exp(1'b0, 1'b0, 32'h500, 32'h0);
    set_port(1'b0, 1'b1, 1'b0, 32'h500, 32'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.cpu_gnt && n < 40);
    check("rst_test_gnt", 64'(bus.cpu_gnt), 1);
    @(negedge clk);
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    do_reset();
    repeat (6) @(negedge clk);
    access(1'b0, 1'b0, 32'h600, 32'h0, 1'b1);
    access(1'b1, 1'b0, 32'h700, 32'h0, 1'b1);
    check("queues_empty", 64'(cpu_q.size() + dma_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
